flag_stack_register: RTL and testbench

- ALU status-flag register, next generation of the 8-bit C/N/P/Z flag register.
- Changes from that block:
  - data width is parameterised;
  - adds an overflow flag V;
  - adds a per-flag update mask;
  - adds a LIFO save/restore stack, so flags survive interrupt entry and subroutine calls.
- Sits between the ALU result bus and the control unit. The stack push/pop strobes come from the interrupt/call sequencer.

---
 rtl/flag_stack_register_pkg.sv | 15 +
 rtl/flag_stack_register_if.sv | 56 +++++
 rtl/flag_stack_register_lifo.sv | 73 +++++++
 rtl/flag_stack_register.sv | 88 ++++++++
 tb/tb_flag_stack_register.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flag_stack_register_pkg.sv
// Shared flag word layout for the ALU status-flag register.
// Exports FLAG_W, bit indices FLG_* and flag_word_t ({V,Z,P,N,C}).
package flag_pkg;

  localparam int FLAG_W = 5;

  localparam int FLG_C = 0;
  localparam int FLG_N = 1;
  localparam int FLG_P = 2;
  localparam int FLG_Z = 3;
  localparam int FLG_V = 4;

  typedef logic [FLAG_W-1:0] flag_word_t;

endpackage

// File: rtl/flag_stack_register_if.sv
// ALU/sequencer bus of the flag register: ALU inputs, stack strobes,
// live flags, stack status. Optional flags_ld/flags_din: FLAG_STACK_LOAD_EN.
interface flag_stack_register_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
);
  import flag_pkg::*;

  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic                  enaf;
  logic [DATA_WIDTH-1:0] dataa;
  logic                  carry;
  logic                  overflow;
  flag_word_t            upd_mask;
  logic                  push;
  logic                  pop;
  logic                  err_clr;
`ifdef FLAG_STACK_LOAD_EN
  logic                  flags_ld;
  flag_word_t            flags_din;
`endif
  logic                  C;
  logic                  N;
  logic                  P;
  logic                  Z;
  logic                  V;
  logic [DW-1:0]         depth;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  ovf_err;
  logic                  unf_err;

  modport master (
    output enaf, dataa, carry, overflow, upd_mask,
    output push, pop, err_clr,
`ifdef FLAG_STACK_LOAD_EN
    output flags_ld, flags_din,
`endif
    input  C, N, P, Z, V,
    input  depth, stack_full, stack_empty,
    input  ovf_err, unf_err
  );

  modport slave (
    input  enaf, dataa, carry, overflow, upd_mask,
    input  push, pop, err_clr,
`ifdef FLAG_STACK_LOAD_EN
    input  flags_ld, flags_din,
`endif
    output C, N, P, Z, V,
    output depth, stack_full, stack_empty,
    output ovf_err, unf_err
  );

endinterface

// File: rtl/flag_stack_register_lifo.sv
// flag_lifo: save/restore stack of flag words with depth count and sticky
// overflow/underflow errors. Ports: clk, rst, push, pop, err_clr, wdata, rdata, depth, full, empty, ovf_err, unf_err.
module flag_lifo
  import flag_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  localparam int DW = $clog2(STACK_DEPTH + 1),
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          err_clr,
  input  flag_word_t    wdata,
  output flag_word_t    rdata,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          ovf_err,
  output logic          unf_err
);

  flag_word_t    mem [STACK_DEPTH];
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_m1;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          both;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;
  logic          unf_set;

  assign full  = (cnt == DW'(STACK_DEPTH));
  assign empty = (cnt == '0);
  assign depth = cnt;

  // push+pop together is illegal: neither moves the stack
  assign both    = push & pop;
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign ovf_set = push & (pop | full);
  assign unf_set = pop & (push | empty);

  assign cnt_m1 = cnt - DW'(1);
  assign wr_idx = cnt[AW-1:0];
  assign rd_idx = cnt_m1[AW-1:0];
  assign rdata  = mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (do_push)
        cnt <= cnt + DW'(1);
      else if (do_pop)
        cnt <= cnt_m1;
      // a new error in the same cycle as err_clr wins
      ovf_err <= ovf_set | (ovf_err & ~err_clr);
      unf_err <= unf_set | (unf_err & ~err_clr);
    end
  end

  // storage needs no reset; depth gates what is readable
  always_ff @(posedge clk) begin
    if (do_push && !both)
      mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/flag_stack_register.sv
// ALU status-flag register {V,Z,P,N,C} with per-flag update mask and LIFO
// save/restore. Ports: clk, rst, bus (slave). Option: FLAG_STACK_LOAD_EN.
module flag_stack_register
  import flag_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  flag_stack_register_if.slave bus
);

  localparam int DW = $clog2(STACK_DEPTH + 1);

  flag_word_t    flags;
  flag_word_t    flags_nx;
  flag_word_t    alu_w;
  flag_word_t    upd_w;
  flag_word_t    rdata;
  logic [DW-1:0] depth;
  logic          full;
  logic          empty;
  logic          ovf_err;
  logic          unf_err;
  logic          pop_ok;

  always_comb begin
    alu_w        = '0;
    alu_w[FLG_C] = bus.carry;
    alu_w[FLG_N] = bus.dataa[DATA_WIDTH-1];
    alu_w[FLG_P] = ~^bus.dataa;
    alu_w[FLG_Z] = (bus.dataa == '0);
    alu_w[FLG_V] = bus.overflow;
  end

  assign upd_w  = (flags & ~bus.upd_mask) | (alu_w & bus.upd_mask);
  assign pop_ok = bus.pop & ~bus.push & ~empty;

  always_comb begin
    flags_nx = flags;
    if (pop_ok)
      flags_nx = rdata;
`ifdef FLAG_STACK_LOAD_EN
    else if (bus.flags_ld)
      flags_nx = bus.flags_din;
`endif
    else if (bus.enaf)
      flags_nx = upd_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flags <= '0;
    else
      flags <= flags_nx;
  end

  // the stack saves the pre-update flags
  flag_lifo #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.push),
    .pop     (bus.pop),
    .err_clr (bus.err_clr),
    .wdata   (flags),
    .rdata   (rdata),
    .depth   (depth),
    .full    (full),
    .empty   (empty),
    .ovf_err (ovf_err),
    .unf_err (unf_err)
  );

  assign bus.C           = flags[FLG_C];
  assign bus.N           = flags[FLG_N];
  assign bus.P           = flags[FLG_P];
  assign bus.Z           = flags[FLG_Z];
  assign bus.V           = flags[FLG_V];
  assign bus.depth       = depth;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.ovf_err     = ovf_err;
  assign bus.unf_err     = unf_err;

endmodule

// File: tb/tb_flag_stack_register.sv
// Bench for flag_stack_register: directed scenarios plus random traffic
// against a queue-based reference model of the flag/stack rules.
module tb_flag_stack_register;
  import flag_pkg::*;

  localparam int DWD = 8;
  localparam int SD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  flag_stack_register_if #(.DATA_WIDTH(DWD), .STACK_DEPTH(SD)) b ();

  flag_stack_register #(
    .DATA_WIDTH  (DWD),
    .STACK_DEPTH (SD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  always #5 clk = ~clk;

  flag_word_t m_flags;
  flag_word_t m_q[$];
  bit         m_ovf;
  bit         m_unf;

  function automatic logic [11:0] obs();
    return {b.V, b.Z, b.P, b.N, b.C, b.depth,
            b.stack_full, b.stack_empty, b.ovf_err, b.unf_err};
  endfunction

  function automatic logic [11:0] expv();
    logic [2:0] d;
    d = 3'(m_q.size());
    return {m_flags, d, m_q.size() == SD, m_q.size() == 0, m_ovf, m_unf};
  endfunction

  function automatic flag_word_t flg();
    return {b.V, b.Z, b.P, b.N, b.C};
  endfunction

  task automatic model_reset();
    m_flags = '0;
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step();
    flag_word_t alu, nxt, old;
    bit so, su;
    so  = 0;
    su  = 0;
    old = m_flags;
    alu[0] = b.carry;
    alu[1] = b.dataa[DWD-1];
    alu[2] = ($countones(b.dataa) % 2) == 0;
    alu[3] = (b.dataa == 0);
    alu[4] = b.overflow;
    nxt = m_flags;
    if (b.enaf)
      for (int i = 0; i < 5; i++)
        if (b.upd_mask[i]) nxt[i] = alu[i];
`ifdef FLAG_STACK_LOAD_EN
    if (b.flags_ld) nxt = b.flags_din;
`endif
    if (b.push && b.pop) begin
      so = 1;
      su = 1;
    end else if (b.pop) begin
      if (m_q.size() > 0) nxt = m_q.pop_back();
      else su = 1;
    end else if (b.push) begin
      if (m_q.size() < SD) m_q.push_back(old);
      else so = 1;
    end
    m_flags = nxt;
    m_ovf = so | (m_ovf & !b.err_clr);
    m_unf = su | (m_unf & !b.err_clr);
  endtask

  task automatic drv(input bit en, input flag_word_t mk,
                     input logic [7:0] d, input bit c, input bit v,
                     input bit pu, input bit po, input bit clr);
    b.enaf     = en;
    b.upd_mask = mk;
    b.dataa    = d;
    b.carry    = c;
    b.overflow = v;
    b.push     = pu;
    b.pop      = po;
    b.err_clr  = clr;
`ifdef FLAG_STACK_LOAD_EN
    b.flags_ld  = 1'b0;
    b.flags_din = '0;
`endif
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    drv(0, 5'h00, 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv(0, 5'h00, 8'h00, 0, 0, 0, 0, 0);
    model_reset();
    n_cmp++;
    if (obs() !== 12'h004) begin
      n_err++;
      $display("FAIL reset obs=%h exp=%h", obs(), 12'h004);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_update();
    drv(1, 5'h1F, 8'h00, 1, 0, 0, 0, 0);
    n_cmp++;
    if (flg() !== 5'h0D || obs() !== expv()) begin
      n_err++;
      $display("FAIL full_update flags=%h exp=%h", flg(), 5'h0D);
    end
  endtask

  task automatic test_mask();
    drv(1, 5'b00100, 8'h01, 0, 0, 0, 0, 0);
    n_cmp++;
    if (flg() !== 5'b01001) begin
      n_err++;
      $display("FAIL mask_setup flags=%b exp=%b", flg(), 5'b01001);
    end
    drv(1, 5'b00010, 8'h80, 1, 1, 0, 0, 0);
    n_cmp++;
    if (flg() !== 5'b01011 || obs() !== expv()) begin
      n_err++;
      $display("FAIL mask_n flags=%b exp=%b", flg(), 5'b01011);
    end
  endtask

  task automatic test_stack();
    flag_word_t want[4];
    want = '{5'h08, 5'h04, 5'h02, 5'h01};
    drv(1, 5'h1F, 8'h01, 1, 0, 0, 0, 0);
    drv(1, 5'h1F, 8'h80, 0, 0, 1, 0, 0);
    drv(1, 5'h1F, 8'h03, 0, 0, 1, 0, 0);
    drv(1, 5'b01000, 8'h00, 0, 0, 1, 0, 0);
    drv(1, 5'b00100, 8'h01, 0, 0, 0, 0, 0);
    n_cmp++;
    if (flg() !== 5'h08) begin
      n_err++;
      $display("FAIL stack_pre flags=%h exp=%h", flg(), 5'h08);
    end
    drv(1, 5'h1F, 8'h05, 1, 1, 1, 0, 0);
    n_cmp++;
    if (b.depth !== 3'd4 || b.stack_full !== 1'b1 || obs() !== expv()) begin
      n_err++;
      $display("FAIL stack_full obs=%h exp=%h", obs(), expv());
    end
    drv(0, 5'h00, 8'h00, 0, 0, 1, 0, 0);
    n_cmp++;
    if (b.ovf_err !== 1'b1 || b.depth !== 3'd4) begin
      n_err++;
      $display("FAIL stack_ovf ovf=%b depth=%0d exp 1/4", b.ovf_err, b.depth);
    end
    for (int i = 0; i < 4; i++) begin
      drv(0, 5'h00, 8'h00, 0, 0, 0, 1, 0);
      n_cmp++;
      if (flg() !== want[i] || obs() !== expv()) begin
        n_err++;
        $display("FAIL stack_pop%0d flags=%h exp=%h", i, flg(), want[i]);
      end
    end
    n_cmp++;
    if (b.stack_empty !== 1'b1 || b.depth !== 3'd0) begin
      n_err++;
      $display("FAIL stack_empty empty=%b depth=%0d exp 1/0",
               b.stack_empty, b.depth);
    end
    drv(0, 5'h00, 8'h00, 0, 0, 0, 0, 1);
  endtask

  task automatic test_underflow();
    drv(1, 5'h1F, 8'h03, 0, 0, 0, 1, 0);
    n_cmp++;
    if (b.unf_err !== 1'b1 || b.Z !== 1'b0 || b.P !== 1'b1 ||
        b.depth !== 3'd0) begin
      n_err++;
      $display("FAIL underflow obs=%h exp=%h", obs(), expv());
    end
    drv(0, 5'h00, 8'h00, 0, 0, 0, 0, 1);
    n_cmp++;
    if (b.unf_err !== 1'b0 || obs() !== expv()) begin
      n_err++;
      $display("FAIL err_clr unf=%b exp=0", b.unf_err);
    end
    drv(0, 5'h00, 8'h00, 0, 0, 0, 1, 1);
    n_cmp++;
    if (b.unf_err !== 1'b1) begin
      n_err++;
      $display("FAIL clr_vs_set unf=%b exp=1", b.unf_err);
    end
    drv(0, 5'h00, 8'h00, 0, 0, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    drv(1, 5'h1F, 8'h03, 1, 0, 0, 0, 0);
    drv(1, 5'h1F, 8'h00, 0, 1, 1, 0, 0);
    n_cmp++;
    if (flg() !== 5'h1C || b.depth !== 3'd1) begin
      n_err++;
      $display("FAIL push_enaf flags=%h depth=%0d exp 1c/1", flg(), b.depth);
    end
    drv(1, 5'h1F, 8'h80, 1, 1, 0, 1, 0);
    n_cmp++;
    if (flg() !== 5'h05 || obs() !== expv()) begin
      n_err++;
      $display("FAIL pop_enaf flags=%h exp=%h", flg(), 5'h05);
    end
    drv(1, 5'h1F, 8'h80, 0, 0, 1, 1, 0);
    n_cmp++;
    if (b.ovf_err !== 1'b1 || b.unf_err !== 1'b1 || flg() !== 5'h02 ||
        b.depth !== 3'd0) begin
      n_err++;
      $display("FAIL push_pop obs=%h exp=%h", obs(), expv());
    end
    drv(0, 5'h00, 8'h00, 0, 0, 0, 0, 1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drv(1, 5'h1F, 8'(i + 1), 1, 1, 1, 0, 0);
    drv(1, 5'h1F, 8'h00, 1, 1, 0, 1, 1);
    drv(0, 5'h00, 8'h00, 0, 0, 1, 0, 0);
    n_cmp++;
    if (b.depth !== 3'd3 || obs() !== expv()) begin
      n_err++;
      $display("FAIL pre_rst obs=%h exp=%h", obs(), expv());
    end
    drv(0, 5'h00, 8'h00, 0, 0, 0, 1, 0);
    drv(0, 5'h00, 8'h00, 0, 0, 1, 1, 0);
    drv(1, 5'h1F, 8'h00, 1, 1, 1, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (obs() !== 12'h004) begin
      n_err++;
      $display("FAIL async_rst obs=%h exp=%h", obs(), 12'h004);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    n_cmp++;
    if (obs() !== expv()) begin
      n_err++;
      $display("FAIL post_rst obs=%h exp=%h", obs(), expv());
    end
  endtask

`ifdef FLAG_STACK_LOAD_EN
  task automatic test_load();
    b.enaf      = 1'b1;
    b.upd_mask  = 5'h00;
    b.dataa     = 8'h00;
    b.push      = 1'b0;
    b.pop       = 1'b0;
    b.err_clr   = 1'b0;
    b.flags_ld  = 1'b1;
    b.flags_din = 5'h1A;
    @(posedge clk);
    model_step();
    @(negedge clk);
    n_cmp++;
    if (flg() !== 5'h1A || obs() !== expv()) begin
      n_err++;
      $display("FAIL load flags=%h exp=%h", flg(), 5'h1A);
    end
    idle();
  endtask
`endif

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      b.enaf     = $urandom_range(0, 1);
      b.upd_mask = 5'($urandom);
      b.dataa    = d;
      b.carry    = $urandom_range(0, 1);
      b.overflow = $urandom_range(0, 1);
      b.push     = ($urandom_range(0, 3) == 0);
      b.pop      = ($urandom_range(0, 3) == 0);
      b.err_clr  = ($urandom_range(0, 15) == 0);
`ifdef FLAG_STACK_LOAD_EN
      b.flags_ld  = ($urandom_range(0, 9) == 0);
      b.flags_din = 5'($urandom);
`endif
      @(posedge clk);
      model_step();
      @(negedge clk);
      n_cmp++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL random%0d obs=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_update();
    test_mask();
    test_stack();
    test_underflow();
    test_back_to_back();
    test_async_reset();
`ifdef FLAG_STACK_LOAD_EN
    test_load();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
